// File: rtl/switch_arbiter.sv
// switch_arbiter: round-robin arbiter for a single shared switch lane.
// A transfer is granted when sender i targets receiver j and receiver j
// expects sender i (self-send never matches). Grants are spaced by a
// three-state IDLE/GRANT/COOL sequence, so at most one every three cycles.
//
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_send_ready     per-core send request
//   i_send_core_idx  per-core destination index
//   i_recv_request   per-core receive request
//   i_recv_core_idx  per-core expected source index
//   o_send_ok        one-cycle pulse to the granted sender
//   o_recv_ready     one-cycle pulse to the granted receiver
//   o_grant_valid    lane transfer active this cycle
//   o_grant_src/dst  lane mux selects, held after the grant
//   o_err_timeout    sticky per-sender timeout flags
//   o_xfer_count     number of completed transfers (wraps)
module switch_arbiter #(
  parameter int CORE_SIZE = 2,
  parameter int TIMEOUT   = 255,
  localparam int CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [CORE_SIZE-1:0]                      i_send_ready,
  input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]  i_send_core_idx,
  input  logic [CORE_SIZE-1:0]                      i_recv_request,
  input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]  i_recv_core_idx,
  output logic [CORE_SIZE-1:0]                      o_send_ok,
  output logic [CORE_SIZE-1:0]                      o_recv_ready,
  output logic                                      o_grant_valid,
  output logic [CORE_ADDR_SIZE-1:0]                 o_grant_src,
  output logic [CORE_ADDR_SIZE-1:0]                 o_grant_dst,
  output logic [CORE_SIZE-1:0]                      o_err_timeout,
  output logic [31:0]                               o_xfer_count
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);
  localparam logic [CORE_SIZE-1:0] ONE_HOT_0 = {{(CORE_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COOL} state_t;

  state_t                    r_state;
  logic [CORE_ADDR_SIZE-1:0] r_rr_ptr;
  logic [CW-1:0]             r_wait_cnt [CORE_SIZE];
  logic [CORE_SIZE-1:0]      r_send_ok;
  logic [CORE_SIZE-1:0]      r_recv_ready;
  logic                      r_grant_valid;
  logic [CORE_ADDR_SIZE-1:0] r_grant_src;
  logic [CORE_ADDR_SIZE-1:0] r_grant_dst;
  logic [CORE_SIZE-1:0]      r_err_timeout;
  logic [31:0]               r_xfer_count;

  logic [CORE_SIZE-1:0]      w_match;
  logic                      w_any;
  logic                      w_fire;
  logic [CORE_ADDR_SIZE-1:0] w_win_src;
  logic [CORE_ADDR_SIZE-1:0] w_win_dst;
  logic [CORE_ADDR_SIZE-1:0] w_rr_next;

  // Sender i matches when its target j is requesting to receive from i.
  // Destinations beyond CORE_SIZE (non power-of-two sizes) never match.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    w_match = '0;
    for (int i = 0; i < CORE_SIZE; i++) begin
      if (int'(i_send_core_idx[i]) < CORE_SIZE && int'(i_send_core_idx[i]) != i) begin
        w_match[i] = i_send_ready[i] &&
                     i_recv_request[i_send_core_idx[i]] &&
                     (i_recv_core_idx[i_send_core_idx[i]] == CORE_ADDR_SIZE'(i));
      end
    end
  end

  // Round-robin scan starting at r_rr_ptr, wrapping modulo CORE_SIZE.
  always_comb begin
    int idx;
    idx       = 0;
    w_any     = 1'b0;
    w_win_src = '0;
    for (int k = 0; k < CORE_SIZE; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= CORE_SIZE) idx = idx - CORE_SIZE;
      if (!w_any && w_match[idx]) begin
        w_any     = 1'b1;
        w_win_src = CORE_ADDR_SIZE'(idx);
      end
    end
  end

  assign w_win_dst = i_send_core_idx[w_win_src];
  assign w_rr_next = (int'(w_win_src) == CORE_SIZE - 1) ? '0 : w_win_src + 1'b1;
  assign w_fire    = (r_state == S_IDLE) && w_any;

  // Control FSM with registered outputs; pulses default low every cycle
  // and are raised only on the edge that enters GRANT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_send_ok     <= '0;
      r_recv_ready  <= '0;
      r_grant_valid <= 1'b0;
      r_grant_src   <= '0;
      r_grant_dst   <= '0;
      r_xfer_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      r_send_ok     <= '0;
      r_recv_ready  <= '0;
      r_grant_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_state       <= S_GRANT;
            r_send_ok     <= ONE_HOT_0 << w_win_src;
            r_recv_ready  <= ONE_HOT_0 << w_win_dst;
            r_grant_valid <= 1'b1;
            r_grant_src   <= w_win_src;
            r_grant_dst   <= w_win_dst;
            r_rr_ptr      <= w_rr_next;
            r_xfer_count  <= r_xfer_count + 32'd1;
          end
        end
        S_GRANT: r_state <= S_COOL;
        S_COOL:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-sender wait counters and sticky timeout flags. A sender stops
  // counting on the edge it wins and while its grant is on the lane.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: this counter array is reset explicitly because the timeout
      // flags depend on it; a plain data array would not need a reset.
      for (int i = 0; i < CORE_SIZE; i++) r_wait_cnt[i] <= '0;
      r_err_timeout <= '0;
    end else begin
      for (int i = 0; i < CORE_SIZE; i++) begin
        if (!i_send_ready[i] ||
            (w_fire && w_win_src == CORE_ADDR_SIZE'(i)) ||
            (r_state == S_GRANT && r_grant_src == CORE_ADDR_SIZE'(i))) begin
          r_wait_cnt[i] <= '0;
        end else if (r_wait_cnt[i] != WAIT_MAX) begin
          r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
        end
        if (r_wait_cnt[i] == WAIT_MAX) r_err_timeout[i] <= 1'b1;
      end
    end
  end

  assign o_send_ok     = r_send_ok;
  assign o_recv_ready  = r_recv_ready;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_src   = r_grant_src;
  assign o_grant_dst   = r_grant_dst;
  assign o_err_timeout = r_err_timeout;
  assign o_xfer_count  = r_xfer_count;

endmodule

// File: tb/tb_switch_arbiter.sv
// Self-checking bench for switch_arbiter with CORE_SIZE=4, TIMEOUT=8.
// Expected grants are queued when stimulus is applied and popped when the
// DUT raises grant_valid.
module tb_switch_arbiter;

  typedef struct packed {
    logic [1:0]  src;
    logic [1:0]  dst;
    logic [31:0] cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      send_ready = '0;
  logic [3:0][1:0] send_idx = '0;
  logic [3:0]      recv_req = '0;
  logic [3:0][1:0] recv_idx = '0;
  logic [3:0]      send_ok;
  logic [3:0]      recv_ready;
  logic            grant_valid;
  logic [1:0]      grant_src;
  logic [1:0]      grant_dst;
  logic [3:0]      err_timeout;
  logic [31:0]     xfer_count;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  switch_arbiter #(.CORE_SIZE(4), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_send_ready(send_ready), .i_send_core_idx(send_idx),
    .i_recv_request(recv_req), .i_recv_core_idx(recv_idx),
    .o_send_ok(send_ok), .o_recv_ready(recv_ready),
    .o_grant_valid(grant_valid), .o_grant_src(grant_src), .o_grant_dst(grant_dst),
    .o_err_timeout(err_timeout), .o_xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    send_ready = '0; send_idx = '0; recv_req = '0; recv_idx = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (at negedges) for grant_valid; a missing grant counts as a failure.
  task automatic wait_grant(input int budget, output int cycles, output bit got);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (grant_valid === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL grant_wait: no grant within %0d cycles, expected one", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({send_ok, recv_ready, grant_valid} !== 9'd0) begin
      n_err++; $display("FAIL reset_pulses: got %b expected 0", {send_ok, recv_ready, grant_valid});
    end
    n_cmp++;
    if ({grant_src, grant_dst} !== 4'd0) begin
      n_err++; $display("FAIL reset_sel: got %b expected 0", {grant_src, grant_dst});
    end
    n_cmp++;
    if (err_timeout !== 4'd0) begin
      n_err++; $display("FAIL reset_err: got %b expected 0000", err_timeout);
    end
    n_cmp++;
    if (xfer_count !== 32'd0) begin
      n_err++; $display("FAIL reset_count: got %0d expected 0", xfer_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (grant_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: got grant_valid=%b expected 0", grant_valid);
    end
  endtask

  task automatic test_basic();
    int cyc; bit got; exp_t e;
    apply_reset();
    send_ready[0] = 1'b1; send_idx[0] = 2'd1;
    recv_req[1]   = 1'b1; recv_idx[1] = 2'd0;
    sb.push_back('{src: 2'd0, dst: 2'd1, cnt: 32'd1});
    wait_grant(10, cyc, got);
    if (got) begin
      e = sb.pop_front();
      n_cmp++;
      if ({send_ok, recv_ready, grant_src, grant_dst, xfer_count, cyc} !==
          {4'b0001 << e.src, 4'b0001 << e.dst, e.src, e.dst, e.cnt, 32'd1}) begin
        n_err++; $display("FAIL basic_grant: got ok=%b rr=%b src=%0d dst=%0d cnt=%0d lat=%0d expected ok=0001 rr=0010 src=0 dst=1 cnt=1 lat=1",
                          send_ok, recv_ready, grant_src, grant_dst, xfer_count, cyc);
      end
    end
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if ({send_ok, recv_ready, grant_valid, grant_src, grant_dst} !== {4'b0, 4'b0, 1'b0, 2'd0, 2'd1}) begin
      n_err++; $display("FAIL basic_after: got ok=%b rr=%b gv=%b src=%0d dst=%0d expected 0,0,0 src=0 dst=1",
                        send_ok, recv_ready, grant_valid, grant_src, grant_dst);
    end
  endtask

  task automatic test_round_robin();
    int cyc; bit got; exp_t e;
    apply_reset();
    send_ready = 4'b1101;
    send_idx[0] = 2'd1; send_idx[2] = 2'd3; send_idx[3] = 2'd2;
    recv_req = 4'b1110;
    recv_idx[1] = 2'd0; recv_idx[3] = 2'd2; recv_idx[2] = 2'd3;
    sb.push_back('{src: 2'd0, dst: 2'd1, cnt: 32'd1});
    sb.push_back('{src: 2'd2, dst: 2'd3, cnt: 32'd2});
    sb.push_back('{src: 2'd3, dst: 2'd2, cnt: 32'd3});
    sb.push_back('{src: 2'd0, dst: 2'd1, cnt: 32'd4});
    for (int g = 0; g < 4; g++) begin
      wait_grant(10, cyc, got);
      if (!got) break;
      e = sb.pop_front();
      n_cmp++;
      if ({send_ok, recv_ready, grant_src, grant_dst, xfer_count} !==
          {4'b0001 << e.src, 4'b0001 << e.dst, e.src, e.dst, e.cnt}) begin
        n_err++; $display("FAIL rr_grant%0d: got src=%0d dst=%0d ok=%b rr=%b cnt=%0d expected src=%0d dst=%0d cnt=%0d",
                          g, grant_src, grant_dst, send_ok, recv_ready, xfer_count, e.src, e.dst, e.cnt);
      end
      n_cmp++;
      if (cyc !== ((g == 0) ? 1 : 3)) begin
        n_err++; $display("FAIL rr_spacing%0d: got %0d cycles expected %0d", g, cyc, (g == 0) ? 1 : 3);
      end
    end
    clear_inputs();
  endtask

  task automatic test_self_send();
    int grants = 0;
    apply_reset();
    send_ready[2] = 1'b1; send_idx[2] = 2'd2;
    recv_req[2]   = 1'b1; recv_idx[2] = 2'd2;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (grant_valid === 1'b1) grants++;
      if (k == 8) begin
        n_cmp++;
        if (err_timeout !== 4'b0000) begin
          n_err++; $display("FAIL self_err_early: got %b expected 0000", err_timeout);
        end
      end
      if (k == 9) begin
        n_cmp++;
        if (err_timeout !== 4'b0100) begin
          n_err++; $display("FAIL self_err_set: got %b expected 0100", err_timeout);
        end
      end
    end
    clear_inputs();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err_timeout !== 4'b0100) begin
      n_err++; $display("FAIL self_err_sticky: got %b expected 0100", err_timeout);
    end
    n_cmp++;
    if (grants !== 0) begin
      n_err++; $display("FAIL self_no_grant: got %0d grants expected 0", grants);
    end
  endtask

  task automatic test_timeout_then_match();
    int cyc; bit got; exp_t e; int grants = 0;
    apply_reset();
    send_ready[0] = 1'b1; send_idx[0] = 2'd1;
    recv_req[1]   = 1'b1; recv_idx[1] = 2'd3;
    repeat (9) begin
      @(negedge clk);
      if (grant_valid === 1'b1) grants++;
    end
    n_cmp++;
    if ({err_timeout, 32'(grants)} !== {4'b0001, 32'd0}) begin
      n_err++; $display("FAIL to_err: got err=%b grants=%0d expected err=0001 grants=0", err_timeout, grants);
    end
    recv_idx[1] = 2'd0;
    sb.push_back('{src: 2'd0, dst: 2'd1, cnt: 32'd1});
    wait_grant(10, cyc, got);
    if (got) begin
      e = sb.pop_front();
      n_cmp++;
      if ({send_ok, recv_ready, grant_src, grant_dst, xfer_count, cyc} !==
          {4'b0001 << e.src, 4'b0001 << e.dst, e.src, e.dst, e.cnt, 32'd1}) begin
        n_err++; $display("FAIL to_grant: got ok=%b rr=%b src=%0d dst=%0d cnt=%0d lat=%0d expected ok=0001 rr=0010 src=0 dst=1 cnt=1 lat=1",
                          send_ok, recv_ready, grant_src, grant_dst, xfer_count, cyc);
      end
      n_cmp++;
      if (dut.r_wait_cnt[0] !== 4'd0) begin
        n_err++; $display("FAIL to_wait_clear: got %0d expected 0", dut.r_wait_cnt[0]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_grant();
    int cyc; bit got; exp_t e;
    apply_reset();
    send_ready[0] = 1'b1; send_idx[0] = 2'd1;
    recv_req[1]   = 1'b1; recv_idx[1] = 2'd0;
    sb.push_back('{src: 2'd0, dst: 2'd1, cnt: 32'd1});
    wait_grant(10, cyc, got);
    if (got) begin
      e = sb.pop_front();
      n_cmp++;
      if ({send_ok, recv_ready, xfer_count} !== {4'b0001 << e.src, 4'b0001 << e.dst, e.cnt}) begin
        n_err++; $display("FAIL mid_pre: got ok=%b rr=%b cnt=%0d expected ok=0001 rr=0010 cnt=1",
                          send_ok, recv_ready, xfer_count);
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({send_ok, recv_ready, grant_valid, xfer_count} !== {4'b0, 4'b0, 1'b0, 32'd0}) begin
      n_err++; $display("FAIL mid_abort: got ok=%b rr=%b gv=%b cnt=%0d expected all 0",
                        send_ok, recv_ready, grant_valid, xfer_count);
    end
    n_cmp++;
    if (dut.r_rr_ptr !== 2'd0) begin
      n_err++; $display("FAIL mid_rr_ptr: got %0d expected 0", dut.r_rr_ptr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{src: 2'd0, dst: 2'd1, cnt: 32'd1});
    wait_grant(10, cyc, got);
    if (got) begin
      e = sb.pop_front();
      n_cmp++;
      if ({send_ok, recv_ready, grant_src, grant_dst, xfer_count, cyc} !==
          {4'b0001 << e.src, 4'b0001 << e.dst, e.src, e.dst, e.cnt, 32'd1}) begin
        n_err++; $display("FAIL mid_regrant: got ok=%b rr=%b src=%0d dst=%0d cnt=%0d lat=%0d expected ok=0001 rr=0010 src=0 dst=1 cnt=1 lat=1",
                          send_ok, recv_ready, grant_src, grant_dst, xfer_count, cyc);
      end
    end
    clear_inputs();
  endtask

  task automatic test_drop_during_grant();
    int cyc; bit got; exp_t e;
    apply_reset();
    send_ready[3] = 1'b1; send_idx[3] = 2'd0;
    recv_req[0]   = 1'b1; recv_idx[0] = 2'd3;
    sb.push_back('{src: 2'd3, dst: 2'd0, cnt: 32'd1});
    wait_grant(10, cyc, got);
    if (got) begin
      clear_inputs();
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({send_ok, recv_ready, grant_valid, xfer_count} !==
          {4'b0001 << e.src, 4'b0001 << e.dst, 1'b1, e.cnt}) begin
        n_err++; $display("FAIL drop_hold: got ok=%b rr=%b gv=%b cnt=%0d expected ok=1000 rr=0001 gv=1 cnt=1",
                          send_ok, recv_ready, grant_valid, xfer_count);
      end
      @(negedge clk);
      n_cmp++;
      if ({send_ok, recv_ready, grant_valid, xfer_count} !== {4'b0, 4'b0, 1'b0, 32'd1}) begin
        n_err++; $display("FAIL drop_after: got ok=%b rr=%b gv=%b cnt=%0d expected 0,0,0 cnt=1",
                          send_ok, recv_ready, grant_valid, xfer_count);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_self_send();
    test_timeout_then_match();
    test_reset_mid_grant();
    test_drop_during_grant();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_empty: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/switch_arbiter.md
SWITCH_ARBITER -- requirements
Module: switch_arbiter

Interface
REQ-001 Parameter CORE_SIZE, default 2, number of cores on the shared switch lane (legal 2..16).
REQ-002 Parameter TIMEOUT, default 255, cycles an unmatched sender may wait before its error flag sets (legal 1..65535).
REQ-003 Parameter CORE_ADDR_SIZE, default $clog2(CORE_SIZE), core index width; derived, never overridden.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; reset=0 asserts immediately, release synchronous to clock.
REQ-006 send_ready  input  [CORE_SIZE] x 1  core i requests to send.
REQ-007 send_core_idx  input  [CORE_SIZE] x CORE_ADDR_SIZE  destination core of sender i.
REQ-008 recv_request  input  [CORE_SIZE] x 1  core j requests to receive.
REQ-009 recv_core_idx  input  [CORE_SIZE] x CORE_ADDR_SIZE  source core expected by receiver j.
REQ-010 send_ok  output  [CORE_SIZE] x 1  one-cycle pulse, sender i's word transferred.
REQ-011 recv_ready  output  [CORE_SIZE] x 1  one-cycle pulse, receiver j's data valid on lane.
REQ-012 grant_valid  output  1  lane transfer active this cycle.
REQ-013 grant_src / grant_dst  output  CORE_ADDR_SIZE each  lane data-mux select, source and destination.
REQ-014 err_timeout  output  [CORE_SIZE] x 1  sticky per-sender timeout flag.
REQ-015 xfer_count  output  32  number of completed transfers.

Function
REQ-016 Match (i,j): send_ready[i] && send_core_idx[i]==j && recv_request[j] && recv_core_idx[j]==i && i!=j; self-send never matches.
REQ-017 FSM states IDLE, GRANT, COOL; IDLE->GRANT when any match sampled at edge, else stay IDLE; GRANT->COOL unconditionally; COOL->IDLE unconditionally.
REQ-018 At most one transfer per three cycles; match sampled at edge t drives GRANT during cycle t+1; earliest next grant cycle t+4.
REQ-019 Selection: scan senders from rr_ptr upward, modulo CORE_SIZE wrap; first sender with a match wins.
REQ-020 On entering GRANT with winner s, rr_ptr <= (s+1) mod CORE_SIZE; rr_ptr==CORE_SIZE-1 with winner at CORE_SIZE-1 wraps to 0.
REQ-021 All outputs registered; in GRANT exactly one send_ok[s] and one recv_ready[d] high, grant_valid=1, grant_src=s, grant_dst=d; all zero in IDLE and COOL.
REQ-022 grant_src/grant_dst hold last granted value outside GRANT.
REQ-023 Committed grant completes even if requester drops send_ready or recv_request during GRANT.
REQ-024 Inputs ignored during GRANT and COOL for matching; cores drop or renew requests in COOL.
REQ-025 wait_cnt[i] (width $clog2(TIMEOUT+1)) increments each cycle send_ready[i]=1 and sender i not in GRANT; clears when send_ready[i]=0 or sender i granted; saturates at TIMEOUT.
REQ-026 err_timeout[i] sets the cycle after wait_cnt[i] reaches TIMEOUT; stays set until reset.
REQ-027 xfer_count increments by 1 on each entry to GRANT; wraps 0xFFFFFFFF->0.

Reset
REQ-028 While reset=0: state IDLE, rr_ptr=0, all wait_cnt=0, send_ok=0, recv_ready=0, grant_valid=0, grant_src=0, grant_dst=0, err_timeout=0, xfer_count=0.
REQ-029 Reset asserted mid-GRANT aborts the transfer: outputs clear asynchronously, xfer_count already-counted value is discarded (cleared to 0).
REQ-030 First match evaluation on first rising edge after reset=1.

Verification (CORE_SIZE=4, TIMEOUT=8)
REQ-031 Core0 send to 1, core1 recv from 0 at edge t -> cycle t+1: send_ok=0001, recv_ready=0010, grant_src=0, grant_dst=1, xfer_count=1; t+2 all pulses 0.
REQ-032 Persistent matches 0->1, 2->3, 3->2 with rr_ptr=0 -> grants in order src 0, 2, 3, 0, spaced 3 cycles; rr_ptr wraps 3->0.
REQ-033 Core2 send to 2 (self) held 10 cycles -> no grant; err_timeout=0100 set after 8 waiting cycles, remains after send_ready drops.
REQ-034 Core0 send to 1, core1 recv from 3 -> no grant; err_timeout[0] sets at cycle 9; then core1 recv_core_idx=0 -> grant, wait_cnt[0]=0.
REQ-035 Match at edge t, reset=0 mid-cycle t+1 -> send_ok, recv_ready, grant_valid drop immediately, xfer_count=0, rr_ptr=0; after release same match granted again.
REQ-036 Sender drops send_ready during GRANT -> send_ok and recv_ready still pulse full cycle; xfer_count increments.
